// File: rtl/urna_pkg.sv
// Shared types and constants for the vote-result display stage.
// Pages cycle C1 -> C2 -> NULL -> WINNER; winner codes match the front-panel LEDs.
package urna_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StCompare,
        StConvert,
        StShow
    } state_e;

    localparam logic [1:0] PG_C1   = 2'b00;
    localparam logic [1:0] PG_C2   = 2'b01;
    localparam logic [1:0] PG_NULL = 2'b10;
    localparam logic [1:0] PG_WIN  = 2'b11;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_C1   = 2'b01;
    localparam logic [1:0] WIN_C2   = 2'b10;
    localparam logic [1:0] WIN_TIE  = 2'b11;

    localparam int unsigned BCD_W = 12;
    localparam int unsigned SEG_W = 21;

    // Double-dabble correction applied to each BCD digit before the shift.
    function automatic logic [3:0] dabble_adj(input logic [3:0] d);
        return (d >= 4'd5) ? (d + 4'd3) : d;
    endfunction

    // Active-low segments, bit 6 = a ... bit 0 = g; non-decimal codes blank.
    function automatic logic [6:0] seg7_of(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b0000001;
            4'd1:    s = 7'b1001111;
            4'd2:    s = 7'b0010010;
            4'd3:    s = 7'b0000110;
            4'd4:    s = 7'b1001100;
            4'd5:    s = 7'b0100100;
            4'd6:    s = 7'b0100000;
            4'd7:    s = 7'b0001111;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0000100;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/urna_bin2bcd_seq.sv
// Sequential double-dabble: start_i loads bin_i, then one shift-add-3 step per cycle;
// done_o pulses for one cycle once bcd_o holds the full conversion.
module urna_bin2bcd_seq
    import urna_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [CNT_W-1:0] bin_i,
    output logic [BCD_W-1:0] bcd_o,
    output logic             done_o
);

    localparam int unsigned CntW = $clog2(CNT_W + 1);

    logic [CNT_W-1:0] bin_q, bin_d;
    logic [BCD_W-1:0] bcd_q, bcd_d;
    logic [BCD_W-1:0] adj;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             done_q, done_d;

    always_comb begin
        adj = '0;
        for (int i = 0; i < BCD_W / 4; i++) begin
            adj[4*i +: 4] = dabble_adj(bcd_q[4*i +: 4]);
        end
    end

    always_comb begin
        bin_d  = bin_q;
        bcd_d  = bcd_q;
        cnt_d  = cnt_q;
        done_d = 1'b0;
        if (start_i) begin
            bin_d = bin_i;
            bcd_d = '0;
            cnt_d = CntW'(CNT_W);
        end else if (cnt_q != '0) begin
            bcd_d  = {adj[BCD_W-2:0], bin_q[CNT_W-1]};
            bin_d  = {bin_q[CNT_W-2:0], 1'b0};
            cnt_d  = cnt_q - CntW'(1);
            done_d = (cnt_q == CntW'(1));
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bin_q  <= '0;
            bcd_q  <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            bcd_q  <= bcd_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign bcd_o  = bcd_q;
    assign done_o = done_q;

endmodule

// File: rtl/urna_result_display.sv
// Result display stage: snapshots final tallies, decides the winner and pages BCD values.
// Optional macro URNA_SEG7_EN adds a registered 3-digit active-low 7-segment output.
module urna_result_display
    import urna_pkg::*;
#(
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned PAGE_CYCLES = 50_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             finish,
    input  logic [CNT_W-1:0] total_c1,
    input  logic [CNT_W-1:0] total_c2,
    input  logic [CNT_W-1:0] total_null,
    output logic [1:0]       winner,
    output logic [1:0]       page,
    output logic [BCD_W-1:0] bcd,
    output logic             bcd_valid,
    output logic             busy
`ifdef URNA_SEG7_EN
    ,
    output logic [SEG_W-1:0] seg
`endif
);

    localparam int unsigned TmrW = $clog2(PAGE_CYCLES);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] c1_q, c1_d, c2_q, c2_d, null_q, null_d;
    logic [1:0]       winner_q, winner_d;
    logic [1:0]       page_q, page_d;
    logic [BCD_W-1:0] bcd_q, bcd_d;
    logic             valid_q, valid_d;
    logic [TmrW-1:0]  timer_q, timer_d;

    logic             conv_start;
    logic [CNT_W-1:0] conv_bin;
    logic [BCD_W-1:0] conv_bcd;
    logic             conv_done;
    logic [CNT_W-1:0] win_val;

    always_comb begin
        state_d    = state_q;
        c1_d       = c1_q;
        c2_d       = c2_q;
        null_d     = null_q;
        winner_d   = winner_q;
        page_d     = page_q;
        bcd_d      = bcd_q;
        valid_d    = valid_q;
        timer_d    = timer_q;
        conv_start = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (finish) begin
                    c1_d    = total_c1;
                    c2_d    = total_c2;
                    null_d  = total_null;
                    state_d = StCompare;
                end
            end
            StCompare: begin
                winner_d   = (c1_q > c2_q) ? WIN_C1 : (c2_q > c1_q) ? WIN_C2 : WIN_TIE;
                page_d     = PG_C1;
                conv_start = 1'b1;
                state_d    = StConvert;
            end
            StConvert: begin
                if (conv_done) begin
                    bcd_d   = conv_bcd;
                    valid_d = 1'b1;
                    timer_d = '0;
                    state_d = StShow;
                end
            end
            StShow: begin
                if (timer_q == TmrW'(PAGE_CYCLES - 1)) begin
                    page_d     = page_q + 2'd1;
                    timer_d    = '0;
                    valid_d    = 1'b0;
                    conv_start = 1'b1;
                    state_d    = StConvert;
                end else begin
                    timer_d = timer_q + TmrW'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        // Dropping finish aborts any run; winner stays for the panel until the next compare.
        if (!finish && (state_q != StIdle)) begin
            state_d    = StIdle;
            valid_d    = 1'b0;
            page_d     = PG_C1;
            timer_d    = '0;
            conv_start = 1'b0;
        end
    end

    always_comb begin
        win_val = '0;
        if (winner_q == WIN_C1) begin
            win_val = CNT_W'(1);
        end else if (winner_q == WIN_C2) begin
            win_val = CNT_W'(2);
        end
    end

    // Converter operand follows the page being entered, not the one being left.
    always_comb begin
        conv_bin = c1_q;
        unique case (page_d)
            PG_C1:   conv_bin = c1_q;
            PG_C2:   conv_bin = c2_q;
            PG_NULL: conv_bin = null_q;
            PG_WIN:  conv_bin = win_val;
            default: conv_bin = c1_q;
        endcase
    end

    urna_bin2bcd_seq #(
        .CNT_W(CNT_W)
    ) u_bin2bcd (
        .clk_i  (clk),
        .rst_i  (rst),
        .start_i(conv_start),
        .bin_i  (conv_bin),
        .bcd_o  (conv_bcd),
        .done_o (conv_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            c1_q     <= '0;
            c2_q     <= '0;
            null_q   <= '0;
            winner_q <= WIN_NONE;
            page_q   <= PG_C1;
            bcd_q    <= '0;
            valid_q  <= 1'b0;
            timer_q  <= '0;
        end else begin
            state_q  <= state_d;
            c1_q     <= c1_d;
            c2_q     <= c2_d;
            null_q   <= null_d;
            winner_q <= winner_d;
            page_q   <= page_d;
            bcd_q    <= bcd_d;
            valid_q  <= valid_d;
            timer_q  <= timer_d;
        end
    end

    assign winner    = winner_q;
    assign page      = page_q;
    assign bcd       = bcd_q;
    assign bcd_valid = valid_q;
    assign busy      = (state_q != StIdle);

`ifdef URNA_SEG7_EN
    logic [SEG_W-1:0] seg_q, seg_d;

    always_comb begin
        seg_d = '1;
        if (valid_q) begin
            seg_d = {seg7_of(bcd_q[11:8]), seg7_of(bcd_q[7:4]), seg7_of(bcd_q[3:0])};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q <= '1;
        end else begin
            seg_q <= seg_d;
        end
    end

    assign seg = seg_q;
`endif

endmodule

// File: tb/tb_urna_result_display.sv
// Scoreboard bench for urna_result_display: expected pages are queued by the stimulus and
// checked by a monitor on every rising edge of bcd_valid.
module tb_urna_result_display;

    localparam int unsigned CNT_W       = 8;
    localparam int unsigned PAGE_CYCLES = 4;

    typedef struct packed {
        logic [1:0]  page;
        logic [11:0] bcd;
        logic [1:0]  winner;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        finish;
    logic [7:0]  total_c1;
    logic [7:0]  total_c2;
    logic [7:0]  total_null;
    logic [1:0]  winner;
    logic [1:0]  page;
    logic [11:0] bcd;
    logic        bcd_valid;
    logic        busy;
`ifdef URNA_SEG7_EN
    logic [20:0] seg;
`endif

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    urna_result_display #(
        .CNT_W      (CNT_W),
        .PAGE_CYCLES(PAGE_CYCLES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .finish    (finish),
        .total_c1  (total_c1),
        .total_c2  (total_c2),
        .total_null(total_null),
        .winner    (winner),
        .page      (page),
        .bcd       (bcd),
        .bcd_valid (bcd_valid),
        .busy      (busy)
`ifdef URNA_SEG7_EN
        ,
        .seg       (seg)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] pg, input logic [11:0] b, input logic [1:0] w);
        exp_t e;
        e.page   = pg;
        e.bcd    = b;
        e.winner = w;
        sb.push_back(e);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 400) begin
            @(posedge clk);
            n++;
        end
        check({"drain_", name}, sb.size(), 0);
        sb.delete();
        #1;
    endtask

    task automatic set_totals(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        total_c1   = a;
        total_c2   = b;
        total_null = c;
    endtask

    // Monitor: each new page presentation is compared against the oldest queued entry.
    initial begin
        logic prev;
        exp_t act;
        exp_t req;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (bcd_valid && !prev) begin
                act.page   = page;
                act.bcd    = bcd;
                act.winner = winner;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_page: got %0h, expected no page", act);
                end else begin
                    req = sb.pop_front();
                    check("page_show", 32'(act), 32'(req));
                end
            end
            prev = bcd_valid;
        end
    end

    initial begin
        rst    = 1'b1;
        finish = 1'b0;
        set_totals(8'd0, 8'd0, 8'd0);
        tick(3);
        rst = 1'b0;
        @(negedge clk);
        check("rst_winner", winner, 2'b00);
        check("rst_page", page, 2'b00);
        check("rst_bcd", bcd, 12'h000);
        check("rst_valid", bcd_valid, 1'b0);
        check("rst_busy", busy, 1'b0);

        // C1 wins; full page rotation including the wrap back to C1.
        tick(1);
        set_totals(8'd37, 8'd12, 8'd5);
        finish = 1'b1;
        push(2'b00, 12'h037, 2'b01);
        push(2'b01, 12'h012, 2'b01);
        push(2'b10, 12'h005, 2'b01);
        push(2'b11, 12'h001, 2'b01);
        push(2'b00, 12'h037, 2'b01);
        tick(10);
        @(negedge clk);
        check("lat_valid_early", bcd_valid, 1'b0);
`ifdef URNA_SEG7_EN
        check("seg_blank", seg, 21'h1FFFFF);
`endif
        tick(1);
        @(negedge clk);
        check("lat_valid", bcd_valid, 1'b1);
        check("lat_bcd", bcd, 12'h037);
        check("lat_page", page, 2'b00);
        check("lat_winner", winner, 2'b01);
`ifdef URNA_SEG7_EN
        check("seg_lag", seg, 21'h1FFFFF);
        @(negedge clk);
        check("seg_037", seg, {7'b0000001, 7'b0000110, 7'b0001111});
`endif
        drain("c1_win");

        // Reset in the middle of a SHOW page.
        check("pre_rst_valid", bcd_valid, 1'b1);
        rst    = 1'b1;
        finish = 1'b0;
        tick(1);
        @(negedge clk);
        check("mid_rst_winner", winner, 2'b00);
        check("mid_rst_page", page, 2'b00);
        check("mid_rst_bcd", bcd, 12'h000);
        check("mid_rst_valid", bcd_valid, 1'b0);
        check("mid_rst_busy", busy, 1'b0);

        // Tie at full scale; tally inputs move after the snapshot and must be ignored.
        tick(1);
        rst = 1'b0;
        set_totals(8'd255, 8'd255, 8'd0);
        finish = 1'b1;
        push(2'b00, 12'h255, 2'b11);
        push(2'b01, 12'h255, 2'b11);
        push(2'b10, 12'h000, 2'b11);
        push(2'b11, 12'h000, 2'b11);
        tick(3);
        set_totals(8'd7, 8'd8, 8'd9);
        drain("tie");
        finish = 1'b0;
        tick(1);
        @(negedge clk);
        check("drop_busy", busy, 1'b0);
        check("drop_valid", bcd_valid, 1'b0);
        check("drop_page", page, 2'b00);
        check("drop_winner_kept", winner, 2'b11);

        // Abort during CONVERT, then restart with new tallies.
        tick(1);
        set_totals(8'd100, 8'd50, 8'd3);
        finish = 1'b1;
        tick(4);
        finish = 1'b0;
        set_totals(8'd9, 8'd40, 8'd1);
        tick(2);
        @(negedge clk);
        check("abort_busy", busy, 1'b0);
        check("abort_valid", bcd_valid, 1'b0);
        check("abort_winner", winner, 2'b01);
        tick(1);
        push(2'b00, 12'h009, 2'b10);
        push(2'b01, 12'h040, 2'b10);
        push(2'b10, 12'h001, 2'b10);
        push(2'b11, 12'h002, 2'b10);
        finish = 1'b1;
        drain("c2_win");
        finish = 1'b0;
        tick(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
